i2s_dac_tx: RTL and testbench

- Drains the sample FIFO (32-bit stereo words: left in the upper half, right in the lower half) and serializes them to the WM8731 DAC in I2S format.
- Acts as audio-interface master: generates BCLK and DACLRC from clk and drives DACDAT.
- Sits between the playback FIFO's read side (rd/empty/r_data, show-ahead data) and the codec pins.

---
 rtl/i2s_dac_tx_if.sv | 11 +
 rtl/i2s_dac_tx.sv | 142 ++++++++++++++
 tb/tb_i2s_dac_tx.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_dac_tx_if.sv
// FIFO read-side bundle between the playback FIFO (slave) and the I2S transmitter (master).
interface i2s_dac_tx_if #(
  parameter int B = 32
);
  logic         fifo_empty;
  logic [B-1:0] fifo_data;
  logic         fifo_rd;

  modport master (input fifo_empty, input fifo_data, output fifo_rd);
  modport slave  (output fifo_empty, output fifo_data, input fifo_rd);
endinterface

// File: rtl/i2s_dac_tx.sv
// I2S master transmitter for the WM8731 DAC: pops one stereo word per frame from a
// show-ahead FIFO and shifts it out MSB-first with the I2S one-bit delay.
module i2s_dac_tx #(
  parameter int B        = 32,
  parameter int SLOT     = 32,
  parameter int BCLK_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             underrun_clr,
  i2s_dac_tx_if.master     fifo,
  output logic             bclk,
  output logic             daclrc,
  output logic             dacdat,
  output logic             underrun
);

  localparam int HALF  = B / 2;
  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int CNT_W = (2 * SLOT > 1) ? $clog2(2 * SLOT) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(2 * SLOT - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [B-1:0]     sample_q, sample_d;
  logic             bclk_q, bclk_d;
  logic             daclrc_q, daclrc_d;
  logic             dacdat_q, dacdat_d;
  logic             fifo_rd_q, fifo_rd_d;
  logic             underrun_q, underrun_d;

  logic             fetch;
  logic [CNT_W-1:0] nxt_bit;
  logic [CNT_W-1:0] pos;
  logic             map_lr;
  logic             map_dat;
  logic [HALF-1:0]  ch_word;
  logic [HALF-1:0]  ch_shift;

  // Pin values for the bit the next falling edge will present.
  always_comb begin
    nxt_bit  = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + CNT_W'(1);
    map_lr   = (nxt_bit >= CNT_W'(SLOT));
    pos      = map_lr ? nxt_bit - CNT_W'(SLOT) : nxt_bit;
    ch_word  = map_lr ? sample_q[HALF-1:0] : sample_q[B-1:HALF];
    ch_shift = ch_word << (pos - CNT_W'(1));
    map_dat  = (pos != '0) && (pos <= CNT_W'(HALF)) && ch_shift[HALF-1];
  end

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    sample_d   = sample_q;
    bclk_d     = bclk_q;
    daclrc_d   = daclrc_q;
    dacdat_d   = dacdat_q;
    fifo_rd_d  = 1'b0;
    underrun_d = underrun_clr ? 1'b0 : underrun_q;
    fetch      = 1'b0;

    case (state_q)
      IDLE: begin
        div_cnt_d = '0;
        bit_cnt_d = '0;
        bclk_d    = 1'b0;
        daclrc_d  = 1'b0;
        dacdat_d  = 1'b0;
        if (enable) begin
          fetch   = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          bclk_d    = ~bclk_q;
          if (bclk_q) begin
            bit_cnt_d = nxt_bit;
            daclrc_d  = map_lr;
            dacdat_d  = map_dat;
            // Frame wrap: bit 0 maps to lrc=0/dat=0, matching the idle pin state.
            if (nxt_bit == '0) begin
              if (enable) fetch   = 1'b1;
              else        state_d = IDLE;
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (fetch) begin
      if (!fifo.fifo_empty) begin
        sample_d  = fifo.fifo_data;
        fifo_rd_d = 1'b1;
      end else begin
        sample_d   = '0;
        underrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      sample_q   <= '0;
      bclk_q     <= 1'b0;
      daclrc_q   <= 1'b0;
      dacdat_q   <= 1'b0;
      fifo_rd_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      sample_q   <= sample_d;
      bclk_q     <= bclk_d;
      daclrc_q   <= daclrc_d;
      dacdat_q   <= dacdat_d;
      fifo_rd_q  <= fifo_rd_d;
      underrun_q <= underrun_d;
    end
  end

  assign fifo.fifo_rd = fifo_rd_q;
  assign bclk         = bclk_q;
  assign daclrc       = daclrc_q;
  assign dacdat       = dacdat_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Directed bench for i2s_dac_tx: main instance (B=32, SLOT=32, BCLK_DIV=2) fed by a
// small FIFO model, plus a corner instance (SLOT=17, BCLK_DIV=1) on a constant word.
module tb_i2s_dac_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic enable = 1'b0;
  logic underrun_clr = 1'b0;
  logic bclk, daclrc, dacdat, underrun;

  logic enable2 = 1'b0;
  logic bclk2, daclrc2, dacdat2, underrun2;

  i2s_dac_tx_if #(.B(32)) intf ();
  i2s_dac_tx_if #(.B(32)) intf2 ();

  i2s_dac_tx #(.B(32), .SLOT(32), .BCLK_DIV(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .underrun_clr(underrun_clr),
    .fifo(intf.master), .bclk(bclk), .daclrc(daclrc), .dacdat(dacdat), .underrun(underrun)
  );

  i2s_dac_tx #(.B(32), .SLOT(17), .BCLK_DIV(1)) dut2 (
    .clk(clk), .reset(reset), .enable(enable2), .underrun_clr(1'b0),
    .fifo(intf2.master), .bclk(bclk2), .daclrc(daclrc2), .dacdat(dacdat2), .underrun(underrun2)
  );

  // Show-ahead FIFO model: head advances on the clock edge that ends a fifo_rd cycle.
  logic [31:0] mem [0:15];
  logic [3:0]  head = '0;
  logic [3:0]  tail = '0;
  assign intf.fifo_empty = (head == tail);
  assign intf.fifo_data  = mem[head];
  always @(posedge clk) if (intf.fifo_rd) head <= head + 4'd1;

  assign intf2.fifo_empty = 1'b0;
  assign intf2.fifo_data  = 32'hC001_8003;

  int cyc = 0;
  int n_rd = 0;
  int bad_rd = 0;
  int rd_cyc [0:15];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (intf.fifo_rd) begin
      if (n_rd < 16) rd_cyc[n_rd] = cyc;
      n_rd++;
      if (intf.fifo_empty) bad_rd++;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    mem[tail] = w;
    tail = tail + 4'd1;
  endtask

  // Expected lrc/dat per bit index for one frame of 2*slot bits.
  function automatic logic [63:0] exp_lr(input int slot);
    logic [63:0] r = '0;
    for (int k = slot; k < 2 * slot; k++) r[k] = 1'b1;
    return r;
  endfunction

  function automatic logic [63:0] exp_dat(input logic [31:0] w, input int slot);
    logic [63:0] r = '0;
    logic [15:0] ch;
    int p;
    for (int k = 0; k < 2 * slot; k++) begin
      p  = k % slot;
      ch = (k >= slot) ? w[15:0] : w[31:16];
      if (p >= 1 && p <= 16) r[k] = ch[16 - p];
    end
    return r;
  endfunction

  // Called in the first cycle of a frame; samples each bit once and bclk low/high phases.
  task automatic capture(input int drop_at, output logic [63:0] lr, output logic [63:0] dat,
                         output logic [63:0] blo, output logic [63:0] bhi);
    lr = '0; dat = '0; blo = '0; bhi = '0;
    for (int k = 0; k < 64; k++) begin
      if (k == drop_at) enable = 1'b0;
      lr[k]  = daclrc;
      dat[k] = dacdat;
      blo[k] = bclk;
      step(); step();
      bhi[k] = bclk;
      step(); step();
    end
  endtask

  task automatic capture2(output logic [63:0] lr, output logic [63:0] dat,
                          output logic [63:0] blo, output logic [63:0] bhi);
    lr = '0; dat = '0; blo = '0; bhi = '0;
    for (int k = 0; k < 34; k++) begin
      lr[k]  = daclrc2;
      dat[k] = dacdat2;
      blo[k] = bclk2;
      step();
      bhi[k] = bclk2;
      step();
    end
  endtask

  localparam logic [31:0] W0 = 32'hA5A5_0F0F;
  localparam logic [31:0] W1 = 32'h1234_8001;
  localparam logic [31:0] W2 = 32'h8001_7FFE;
  localparam logic [31:0] W3 = 32'h5A5A_C3C3;
  localparam logic [31:0] W4 = 32'h0F0F_F0F0;
  localparam logic [31:0] W5 = 32'hDEAD_BEEF;

  initial begin
    logic [63:0] lr, dat, blo, bhi;
    logic [3:0]  acc;

    push(W0); push(W1); push(W2);
    repeat (3) step();
    check("reset_outs", {59'd0, bclk, daclrc, dacdat, intf.fifo_rd, underrun}, 64'd0);
    reset = 1'b0;
    step();

    // Start and three back-to-back frames, then an underrun frame.
    enable = 1'b1;
    step();
    check("start_rd", {63'd0, intf.fifo_rd}, 64'd1);
    capture(-1, lr, dat, blo, bhi);
    check("f0_lr", lr, exp_lr(32));
    check("f0_dat", dat, exp_dat(W0, 32));
    check("f0_bclk_lo", blo, 64'd0);
    check("f0_bclk_hi", bhi, {64{1'b1}});
    check("f0_underrun", {63'd0, underrun}, 64'd0);
    capture(-1, lr, dat, blo, bhi);
    check("f1_dat", dat, exp_dat(W1, 32));
    capture(-1, lr, dat, blo, bhi);
    check("f2_dat", dat, exp_dat(W2, 32));
    check("under_set", {63'd0, underrun}, 64'd1);
    capture(-1, lr, dat, blo, bhi);
    check("f3_dat_zero", dat, 64'd0);
    check("f3_lr", lr, exp_lr(32));
    check("rd_count3", 64'(n_rd), 64'd3);
    check("rd_gap01", 64'(rd_cyc[1] - rd_cyc[0]), 64'd256);
    check("rd_gap12", 64'(rd_cyc[2] - rd_cyc[1]), 64'd256);

    // Clear, then a clear that coincides with a new underrun.
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    check("under_clr", {63'd0, underrun}, 64'd0);
    repeat (254) step();
    check("under_held_clr", {63'd0, underrun}, 64'd0);
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    check("under_set_beats_clr", {63'd0, underrun}, 64'd1);

    // Refill; next wrap resumes, then stop requested at bit 10.
    push(W3); push(W4); push(W5);
    repeat (256) step();
    check("restart_rd", {63'd0, intf.fifo_rd}, 64'd1);
    capture(10, lr, dat, blo, bhi);
    check("f6_dat", dat, exp_dat(W3, 32));
    check("f6_lr", lr, exp_lr(32));
    acc = '0;
    for (int i = 0; i < 40; i++) begin
      acc = acc | {bclk, daclrc, dacdat, intf.fifo_rd};
      step();
    end
    check("stop_quiet", {60'd0, acc}, 64'd0);
    check("stop_rd_count", 64'(n_rd), 64'd4);

    // Reset at bit 20 of a frame, held for a cycle with enable high.
    enable = 1'b1;
    step();
    check("rerun_rd", {63'd0, intf.fifo_rd}, 64'd1);
    repeat (80) step();
    reset = 1'b1;
    step();
    check("midrst_outs", {59'd0, bclk, daclrc, dacdat, intf.fifo_rd, underrun}, 64'd0);
    step();
    check("rst_en_no_rd", {63'd0, intf.fifo_rd}, 64'd0);
    reset = 1'b0;
    step();
    check("post_rst_rd", {63'd0, intf.fifo_rd}, 64'd1);
    capture(0, lr, dat, blo, bhi);
    check("f7_dat", dat, exp_dat(W5, 32));
    check("rd_count_final", 64'(n_rd), 64'd6);
    check("rd_while_empty", 64'(bad_rd), 64'd0);

    // Corner instance: bclk toggles every clk, 34-bclk frame, no padding bits.
    enable2 = 1'b1;
    step();
    check("c_start_rd", {63'd0, intf2.fifo_rd}, 64'd1);
    capture2(lr, dat, blo, bhi);
    check("c_lr", lr, exp_lr(17));
    check("c_dat", dat, exp_dat(32'hC001_8003, 17));
    check("c_bclk_lo", blo, 64'd0);
    check("c_bclk_hi", bhi, {30'd0, {34{1'b1}}});
    check("c_wrap_rd", {63'd0, intf2.fifo_rd}, 64'd1);
    enable2 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
